cache_arbiter: RTL and testbench

Two-port arbiter placed in front of the single direct-mapped cache controller. It shares the controller between the instruction-fetch port (read only) and the data port (read/write). It latches the winning request and holds it stable on the controller inputs until the controller's done pulse, then routes the result back to that requester. Data is favoured, with a bounded streak so fetch cannot starve. It also keeps per-port access and hit counters.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/sat_counter.sv | 16 +
 rtl/cache_arbiter.sv | 149 ++++++++++++++
 tb/tb_cache_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and widths for the cache front-end: arbiter state encoding
// and the latched request payload.
package cache_pkg;
   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned STREAK_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY_I = 2'b01,
      BUSY_D = 2'b10
   } arb_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              read;
      logic              write;
   } req_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end
endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache controller between the fetch port and the data port.
// Data is favoured, but a bounded grant streak keeps fetch from starving.
module cache_arbiter
   import cache_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic              i_done,
   output logic [DATA_W-1:0] i_data_out,
   output logic              i_cachehit,
   output logic              i_err,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data_in,
   input  logic              d_read,
   input  logic              d_write,
   output logic              d_done,
   output logic [DATA_W-1:0] d_data_out,
   output logic              d_cachehit,
   output logic              d_err,
   output logic [ADDR_W-1:0] ctl_addr,
   output logic [DATA_W-1:0] ctl_data_in,
   output logic              ctl_read,
   output logic              ctl_write,
   input  logic [DATA_W-1:0] ctl_data_out,
   input  logic              ctl_done,
   input  logic              ctl_cachehit,
   input  logic              ctl_err,
   output logic [CNT_W-1:0]  cnt_i_acc,
   output logic [CNT_W-1:0]  cnt_i_hit,
   output logic [CNT_W-1:0]  cnt_d_acc,
   output logic [CNT_W-1:0]  cnt_d_hit
);
   arb_state_t          state, state_nx;
   req_t                req_q, req_nx;
   logic [STREAK_W-1:0] streak_q, streak_nx;

   logic d_bad, d_req, grant_d, grant_i;
   logic inc_i_acc, inc_i_hit, inc_d_acc, inc_d_hit;

   // State register, request latch and data streak
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_q    <= '0;
         streak_q <= '0;
      end else begin
         state    <= state_nx;
         req_q    <= req_nx;
         streak_q <= streak_nx;
      end
   end

   // Grant decision, controller drive and result routing
   always_comb begin
      state_nx    = state;
      req_nx      = req_q;
      streak_nx   = streak_q;
      d_bad       = 1'b0;
      d_req       = 1'b0;
      grant_d     = 1'b0;
      grant_i     = 1'b0;
      i_done      = 1'b0;
      i_data_out  = '0;
      i_cachehit  = 1'b0;
      i_err       = 1'b0;
      d_done      = 1'b0;
      d_data_out  = '0;
      d_cachehit  = 1'b0;
      d_err       = 1'b0;
      ctl_addr    = '0;
      ctl_data_in = '0;
      ctl_read    = 1'b0;
      ctl_write   = 1'b0;
      inc_i_acc   = 1'b0;
      inc_i_hit   = 1'b0;
      inc_d_acc   = 1'b0;
      inc_d_hit   = 1'b0;

      unique case (state)
         IDLE: begin
            // A simultaneous load+store is rejected at once; fetch is still eligible
            d_bad   = d_read & d_write;
            d_req   = (d_read | d_write) & ~d_bad;
            grant_d = d_req & (~i_read | (streak_q < STREAK_W'(MAX_D_STREAK)));
            grant_i = i_read & ~grant_d;
            if (d_bad) begin
               d_done = 1'b1;
               d_err  = 1'b1;
            end
            if (grant_d) begin
               req_nx.addr  = d_addr;
               req_nx.data  = d_data_in;
               req_nx.read  = d_read;
               req_nx.write = d_write;
               streak_nx    = i_read ? streak_q + STREAK_W'(1) : '0;
               state_nx     = BUSY_D;
            end else if (grant_i) begin
               req_nx.addr  = i_addr;
               req_nx.data  = '0;
               req_nx.read  = 1'b1;
               req_nx.write = 1'b0;
               streak_nx    = '0;
               state_nx     = BUSY_I;
            end
         end
         BUSY_I: begin
            ctl_addr    = req_q.addr;
            ctl_data_in = req_q.data;
            ctl_read    = req_q.read;
            ctl_write   = req_q.write;
            if (ctl_done) begin
               i_done     = 1'b1;
               i_data_out = ctl_data_out;
               i_cachehit = ctl_cachehit;
               i_err      = ctl_err;
               inc_i_acc  = 1'b1;
               inc_i_hit  = ctl_cachehit;
               state_nx   = IDLE;
            end
         end
         BUSY_D: begin
            ctl_addr    = req_q.addr;
            ctl_data_in = req_q.data;
            ctl_read    = req_q.read;
            ctl_write   = req_q.write;
            if (ctl_done) begin
               d_done     = 1'b1;
               d_data_out = ctl_data_out;
               d_cachehit = ctl_cachehit;
               d_err      = ctl_err;
               inc_d_acc  = 1'b1;
               inc_d_hit  = ctl_cachehit;
               state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_cnt_i_acc (.clk(clk), .rst_n(rst_n), .inc(inc_i_acc), .count(cnt_i_acc));
   sat_counter #(.W(CNT_W)) u_cnt_i_hit (.clk(clk), .rst_n(rst_n), .inc(inc_i_hit), .count(cnt_i_hit));
   sat_counter #(.W(CNT_W)) u_cnt_d_acc (.clk(clk), .rst_n(rst_n), .inc(inc_d_acc), .count(cnt_d_acc));
   sat_counter #(.W(CNT_W)) u_cnt_d_hit (.clk(clk), .rst_n(rst_n), .inc(inc_d_hit), .count(cnt_d_hit));
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small behavioural cache controller;
// a second instance with 2-bit counters exposes saturation quickly.
module tb_cache_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_addr, d_addr, d_data_in;
   logic        i_read, d_read, d_write;
   logic        i_done, i_cachehit, i_err, d_done, d_cachehit, d_err;
   logic [15:0] i_data_out, d_data_out;
   logic [15:0] ctl_addr, ctl_data_in, ctl_data_out;
   logic        ctl_read, ctl_write, ctl_done, ctl_cachehit, ctl_err;
   logic [15:0] cnt_i_acc, cnt_i_hit, cnt_d_acc, cnt_d_hit;

   logic        s_i_done, s_i_cachehit, s_i_err, s_d_done, s_d_cachehit, s_d_err;
   logic [15:0] s_i_data_out, s_d_data_out, s_ctl_addr, s_ctl_data_in;
   logic        s_ctl_read, s_ctl_write;
   logic [1:0]  s_cnt_i_acc, s_cnt_i_hit, s_cnt_d_acc, s_cnt_d_hit;

   int total = 0;
   int bad   = 0;
   int lat   = 1;
   int m_cnt;

   always #5 clk = ~clk;

   cache_arbiter #(.MAX_D_STREAK(3), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_read(i_read), .i_done(i_done), .i_data_out(i_data_out),
      .i_cachehit(i_cachehit), .i_err(i_err),
      .d_addr(d_addr), .d_data_in(d_data_in), .d_read(d_read), .d_write(d_write),
      .d_done(d_done), .d_data_out(d_data_out), .d_cachehit(d_cachehit), .d_err(d_err),
      .ctl_addr(ctl_addr), .ctl_data_in(ctl_data_in), .ctl_read(ctl_read), .ctl_write(ctl_write),
      .ctl_data_out(ctl_data_out), .ctl_done(ctl_done), .ctl_cachehit(ctl_cachehit), .ctl_err(ctl_err),
      .cnt_i_acc(cnt_i_acc), .cnt_i_hit(cnt_i_hit), .cnt_d_acc(cnt_d_acc), .cnt_d_hit(cnt_d_hit));

   cache_arbiter #(.MAX_D_STREAK(3), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_read(i_read), .i_done(s_i_done), .i_data_out(s_i_data_out),
      .i_cachehit(s_i_cachehit), .i_err(s_i_err),
      .d_addr(d_addr), .d_data_in(d_data_in), .d_read(d_read), .d_write(d_write),
      .d_done(s_d_done), .d_data_out(s_d_data_out), .d_cachehit(s_d_cachehit), .d_err(s_d_err),
      .ctl_addr(s_ctl_addr), .ctl_data_in(s_ctl_data_in), .ctl_read(s_ctl_read), .ctl_write(s_ctl_write),
      .ctl_data_out(ctl_data_out), .ctl_done(ctl_done), .ctl_cachehit(ctl_cachehit), .ctl_err(ctl_err),
      .cnt_i_acc(s_cnt_i_acc), .cnt_i_hit(s_cnt_i_hit), .cnt_d_acc(s_cnt_d_acc), .cnt_d_hit(s_cnt_d_hit));

   // Controller model: done after lat cycles; data = addr^5A5A, hit = even addr, err = addr[15]
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_done <= 1'b0; ctl_data_out <= '0; ctl_cachehit <= 1'b0; ctl_err <= 1'b0; m_cnt <= 0;
      end else if (ctl_done) begin
         ctl_done <= 1'b0; m_cnt <= 0;
      end else if (ctl_read || ctl_write) begin
         if (m_cnt >= lat - 1) begin
            ctl_done     <= 1'b1;
            ctl_data_out <= ctl_addr ^ 16'h5A5A;
            ctl_cachehit <= ~ctl_addr[0];
            ctl_err      <= ctl_addr[15];
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_i(input int max, output bit seen);
      seen = 0;
      for (int c = 0; c < max; c++) begin
         @(negedge clk);
         if (i_done) begin seen = 1; return; end
      end
   endtask

   task automatic run_fetch(input logic [15:0] a, output bit seen, output logic [15:0] data);
      @(negedge clk);
      i_addr = a; i_read = 1'b1;
      wait_i(60, seen);
      data = i_data_out;
      i_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
      i_addr = '0; d_addr = '0; d_data_in = '0;
      #1;
      total++; if ({ctl_read, ctl_write, i_done, d_done, d_err, i_err} !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=000000", {ctl_read, ctl_write, i_done, d_done, d_err, i_err}); end
      total++; if ({cnt_i_acc, cnt_i_hit, cnt_d_acc, cnt_d_hit} !== 64'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", {cnt_i_acc, cnt_i_hit, cnt_d_acc, cnt_d_hit}); end
      total++; if (ctl_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", ctl_addr); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      bit seen;
      lat = 2;
      @(negedge clk);
      i_addr = 16'h0100; i_read = 1'b1;
      total++; if (ctl_read !== 1'b0) begin bad++; $display("FAIL fetch_pre_rd got=%b exp=0", ctl_read); end
      @(negedge clk);
      total++; if (ctl_read !== 1'b1) begin bad++; $display("FAIL fetch_ctl_rd got=%b exp=1", ctl_read); end
      total++; if (ctl_addr !== 16'h0100) begin bad++; $display("FAIL fetch_ctl_addr got=%h exp=0100", ctl_addr); end
      wait_i(10, seen);
      total++; if (!seen) begin bad++; $display("FAIL fetch_done got=0 exp=1"); end
      total++; if (i_data_out !== 16'h5B5A) begin bad++; $display("FAIL fetch_data got=%h exp=5b5a", i_data_out); end
      total++; if ({i_cachehit, i_err, d_done} !== 3'b100) begin bad++; $display("FAIL fetch_flags got=%b exp=100", {i_cachehit, i_err, d_done}); end
      i_read = 1'b0;
      @(negedge clk);
      total++; if (cnt_i_acc !== 16'd1 || cnt_i_hit !== 16'd1) begin bad++; $display("FAIL fetch_cnt got=%0d/%0d exp=1/1", cnt_i_acc, cnt_i_hit); end
      total++; if (ctl_read !== 1'b0 || i_done !== 1'b0) begin bad++; $display("FAIL fetch_bubble got=%b%b exp=00", ctl_read, i_done); end
   endtask

   task automatic test_store_delay();
      int dones = 0, busy = 0, bad_data = 0;
      lat = 20;
      @(negedge clk);
      d_addr = 16'h2008; d_data_in = 16'hBEEF; d_write = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ctl_write) begin
            busy++;
            if (ctl_data_in !== 16'hBEEF || ctl_addr !== 16'h2008) bad_data++;
         end
         if (d_done) begin
            dones++;
            total++; if (d_cachehit !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL store_flags got=%b%b exp=10", d_cachehit, d_err); end
            d_write = 1'b0;
         end
         d_data_in = 16'($urandom);
         d_addr    = 16'($urandom) & 16'h7FFE;
      end
      total++; if (bad_data != 0) begin bad++; $display("FAIL store_hold got=%0d exp=0 bad cycles", bad_data); end
      total++; if (dones != 1) begin bad++; $display("FAIL store_done_count got=%0d exp=1", dones); end
      total++; if (busy != 21) begin bad++; $display("FAIL store_busy_cycles got=%0d exp=21", busy); end
      total++; if (cnt_d_acc !== 16'd1 || cnt_d_hit !== 16'd1) begin bad++; $display("FAIL store_cnt got=%0d/%0d exp=1/1", cnt_d_acc, cnt_d_hit); end
   endtask

   task automatic test_arb_order();
      logic [7:0] exp_d = 8'b1110_1110;
      logic [7:0] got_d = '0;
      int n = 0;
      lat = 1;
      @(negedge clk);
      i_addr = 16'h0040; d_addr = 16'h8004; i_read = 1'b1; d_read = 1'b1;
      for (int c = 0; c < 100 && n < 8; c++) begin
         @(negedge clk);
         if (d_done && i_done) begin
            total++; bad++; $display("FAIL arb_both_done got=11 exp=single");
         end
         if (d_done) begin
            got_d[7-n] = 1'b1; n++;
            total++; if (d_err !== 1'b1 || d_data_out !== 16'hDA5E) begin bad++; $display("FAIL arb_d_result got=%b/%h exp=1/da5e", d_err, d_data_out); end
         end else if (i_done) begin
            got_d[7-n] = 1'b0; n++;
            total++; if (i_err !== 1'b0 || i_data_out !== 16'h5A1A) begin bad++; $display("FAIL arb_i_result got=%b/%h exp=0/5a1a", i_err, i_data_out); end
         end
         if (n == 8) begin i_read = 1'b0; d_read = 1'b0; end
      end
      i_read = 1'b0; d_read = 1'b0;
      total++; if (n != 8) begin bad++; $display("FAIL arb_timeout got=%0d exp=8 completions", n); end
      total++; if (got_d !== exp_d) begin bad++; $display("FAIL arb_order got=%b exp=%b (1=D)", got_d, exp_d); end
      @(negedge clk);
      total++; if (cnt_d_acc !== 16'd7 || cnt_i_acc !== 16'd3) begin bad++; $display("FAIL arb_cnt got=%0d/%0d exp=7/3", cnt_d_acc, cnt_i_acc); end
   endtask

   task automatic test_illegal();
      bit seen;
      do_reset();
      lat = 1;
      @(negedge clk);
      d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0500;
      #1;
      total++; if ({d_done, d_err, ctl_read, ctl_write} !== 4'b1100) begin bad++; $display("FAIL illegal_pulse got=%b exp=1100", {d_done, d_err, ctl_read, ctl_write}); end
      d_read = 1'b0; d_write = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if ({ctl_read, ctl_write, d_done} !== 3'b000) begin bad++; $display("FAIL illegal_quiet got=%b exp=000", {ctl_read, ctl_write, d_done}); end
      end
      @(negedge clk);
      i_addr = 16'h0300; i_read = 1'b1; d_read = 1'b1; d_write = 1'b1;
      #1;
      total++; if ({d_done, d_err} !== 2'b11) begin bad++; $display("FAIL illegal_with_i got=%b exp=11", {d_done, d_err}); end
      d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      total++; if (ctl_read !== 1'b1 || ctl_write !== 1'b0 || ctl_addr !== 16'h0300) begin bad++; $display("FAIL illegal_i_grant got=%b%b/%h exp=10/0300", ctl_read, ctl_write, ctl_addr); end
      wait_i(10, seen);
      i_read = 1'b0;
      @(negedge clk);
      total++; if (!seen || cnt_i_acc !== 16'd1 || cnt_d_acc !== 16'd0) begin bad++; $display("FAIL illegal_cnt got=%b/%0d/%0d exp=1/1/0", seen, cnt_i_acc, cnt_d_acc); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      logic [15:0] data;
      int spurious = 0;
      lat = 20;
      @(negedge clk);
      d_addr = 16'h1234; d_read = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (ctl_read !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", ctl_read); end
      rst_n = 1'b0;
      #1;
      total++; if ({ctl_read, ctl_write, d_done, i_done} !== 4'b0 || ctl_addr !== 16'h0 || cnt_i_acc !== 16'h0) begin bad++; $display("FAIL mid_rst_out got=%b/%h/%0d exp=0000/0000/0", {ctl_read, ctl_write, d_done, i_done}, ctl_addr, cnt_i_acc); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (d_done || i_done) spurious++;
      end
      d_read = 1'b0;
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); if (d_done || i_done) spurious++; end
      total++; if (spurious != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", spurious); end
      lat = 2;
      run_fetch(16'h0100, seen, data);
      total++; if (!seen || data !== 16'h5B5A) begin bad++; $display("FAIL mid_refetch got=%b/%h exp=1/5b5a", seen, data); end
      total++; if (cnt_i_acc !== 16'd1 || cnt_d_acc !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d/%0d exp=1/0", cnt_i_acc, cnt_d_acc); end
   endtask

   task automatic test_saturate();
      bit seen;
      logic [15:0] data;
      int missed = 0;
      do_reset();
      lat = 1;
      for (int k = 0; k < 4; k++) begin
         run_fetch(16'h0010 + 16'(k * 2), seen, data);
         if (!seen) missed++;
      end
      total++; if (missed != 0) begin bad++; $display("FAIL sat_timeout got=%0d exp=0 missed", missed); end
      total++; if (s_cnt_i_hit !== 2'd3 || s_cnt_i_acc !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=3/3", s_cnt_i_hit, s_cnt_i_acc); end
      total++; if (cnt_i_hit !== 16'd4) begin bad++; $display("FAIL sat_wide got=%0d exp=4", cnt_i_hit); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_delay();
      test_arb_order();
      test_illegal();
      test_reset_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
